addsub_acc_seq: RTL and testbench
=================================

// Module: addsub_acc_seq
// PURPOSE
// - Sequencing accumulator wrapped around the combinational add_sub datapath (A,B,Cin,Sum,Cout).
// - Accepts op/operand commands over a valid/ready handshake and drives add_sub with A=acc, B=operand.
// - Captures Sum/Cout back into the accumulator and returns the result and flags over a second handshake.
// - add_sub is instantiated alongside this block; Cin=1 selects A-B (two's complement), and Cout=1 means no borrow.
// PARAMETERS
// - WIDTH   4   datapath width; must match the add_sub instance
// PORTS
// - clk        in   1      rising-edge clock
// - rst        in   1      synchronous reset, active-high
// - in_valid   in   1      command valid
// - in_ready   out  1      command accepted when in_valid & in_ready at clk edge
// - in_op      in   2      00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
// - in_data    in   WIDTH  operand (ignored for CLEAR)
// - as_a       out  WIDTH  to add_sub A
// - as_b       out  WIDTH  to add_sub B
// - as_cin     out  1      to add_sub Cin (0 add, 1 sub)
// - as_sum     in   WIDTH  from add_sub Sum
// - as_cout    in   1      from add_sub Cout
// - out_valid  out  1      result valid; held until out_ready
// - out_ready  in   1      result consumed when out_valid & out_ready at clk edge
// - acc        out  WIDTH  accumulator value (registered)
// - carry      out  1      registered Cout of last ADD/SUB; 0 after LOAD/CLEAR
// - ovf        out  1      registered signed overflow of last ADD/SUB; 0 after LOAD/CLEAR
// - zero       out  1      combinational (acc == 0)
// BEHAVIOUR
// - Reset values (next edge with rst=1, any state):
//   - state=IDLE; acc, carry, ovf, as_a, as_b and as_cin = 0; out_valid=0; in_ready=1.
//   - Any in-flight command is dropped, and no out_valid is produced for it.
// - FSM states: IDLE, EXEC, RESP.
//   - in_ready=1 only in IDLE; out_valid=1 only in RESP.
// - IDLE, accept at edge E0 with ADD/SUB:
//   - Register as_a=acc, as_b=in_data, as_cin=in_op[0]; go to EXEC.
// - EXEC (one cycle):
//   - At edge E1: acc<=as_sum, carry<=as_cout, ovf<=signed overflow; go to RESP.
//   - out_valid rises in the cycle after E1 (accept to result = 2 edges).
// - IDLE, accept at E0 with LOAD: acc<=in_data, carry<=0, ovf<=0; go to RESP (1 edge).
// - IDLE, accept at E0 with CLEAR: acc<=0, carry<=0, ovf<=0; go to RESP (1 edge).
// - RESP:
//   - acc, carry and ovf are held stable.
//   - out_ready=1 at edge -> IDLE. No back-to-back accept on the same edge.
// - Overflow rule (msb = WIDTH-1):
//   - ADD: ovf = (a[msb]==b[msb]) & (sum[msb]!=a[msb]).
//   - SUB: ovf = (a[msb]!=b[msb]) & (sum[msb]!=a[msb]).
// - Arithmetic wraps modulo 2^WIDTH unless ACC_SAT_EN is defined.
// - in_valid/in_data are ignored outside IDLE; out_ready is ignored outside RESP.
// - as_a, as_b and as_cin hold their last value outside EXEC.
// CONFIGURATION
// - ACC_SAT_EN defined: on ADD/SUB with ovf=1, acc saturates instead of taking as_sum.
//   - Saturates to 0111..1 if as_a[msb]=0, else to 100..0.
//   - carry and ovf are still reported as computed.
// - ACC_SAT_EN undefined: acc<=as_sum always (wrap-around).
// TESTING (WIDTH=4, add_sub instantiated and wired to as_*)
// - Reset: rst=1 for 2 cycles -> acc=0000, zero=1, in_ready=1, out_valid=0, carry=0, ovf=0.
// - LOAD 1001, then ADD 1110:
//   - Without ACC_SAT_EN -> acc=0111, carry=1, ovf=1.
//   - With ACC_SAT_EN -> acc=1000, ovf=1.
//   - out_valid appears 2 edges after the ADD accept.
// - LOAD 0011, then SUB 0101 -> acc=1110, carry=0, ovf=0, zero=0.
//   - LOAD 0101, SUB 0011 -> acc=0010, carry=1.
// - Backpressure: hold out_ready=0 for 5 cycles after ADD while pulsing in_valid.
//   - Required: out_valid stays 1, acc stable, in_ready=0, no command accepted.
// - Reset mid-op: assert rst in the EXEC cycle -> next cycle state IDLE, acc=0000, out_valid=0.
//   - The following out_ready pulse has no effect.
// - CLEAR from acc=1010 -> out_valid 1 edge after accept, acc=0000, zero=1, carry=0, ovf=0.

Source files
------------

// File: rtl/addsub_acc_seq.sv
// Accumulator sequencer around an external add_sub datapath: ADD/SUB/LOAD/CLEAR commands in, result and flags out.
// Define ACC_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module addsub_acc_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_cin,
  input  logic [WIDTH-1:0] as_sum,
  input  logic             as_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  // state | meaning
  // IDLE  | ready for a command
  // EXEC  | add_sub operands registered, result captured at next edge
  // RESP  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam int         MSB      = WIDTH - 1;

  state_t state_q, state_d;
  logic   accept;
  logic   ovf_calc;
  logic [WIDTH-1:0] acc_next;

  assign accept    = (state_q == IDLE) && in_valid;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign zero      = (acc == '0);

  // as_b is the raw operand; add_sub does the inversion for subtraction
  assign ovf_calc = as_cin ? ((as_a[MSB] != as_b[MSB]) && (as_sum[MSB] != as_a[MSB]))
                           : ((as_a[MSB] == as_b[MSB]) && (as_sum[MSB] != as_a[MSB]));

`ifdef ACC_SAT_EN
  always_comb begin
    acc_next = as_sum;
    if (ovf_calc)
      acc_next = as_a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
  end
`else
  assign acc_next = as_sum;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = in_op[1] ? RESP : EXEC;
      EXEC: state_d = RESP;
      RESP: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc     <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      as_a    <= '0;
      as_b    <= '0;
      as_cin  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        case (in_op)
          OP_ADD, OP_SUB: begin
            as_a   <= acc;
            as_b   <= in_data;
            as_cin <= in_op[0];
          end
          OP_LOAD: begin
            acc   <= in_data;
            carry <= 1'b0;
            ovf   <= 1'b0;
          end
          OP_CLEAR: begin
            acc   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
          end
          default: ;
        endcase
      end else if (state_q == EXEC) begin
        acc   <= acc_next;
        carry <= as_cout;
        ovf   <= ovf_calc;
      end
    end
  end

endmodule

// File: tb/tb_addsub_acc_seq.sv
// Scoreboard bench for addsub_acc_seq with a behavioural add_sub and an arithmetic reference model.
module tb_addsub_acc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic [3:0] as_a, as_b, as_sum;
  logic       as_cin, as_cout;
  logic       out_valid, out_ready;
  logic [3:0] acc;
  logic       carry, ovf, zero;
  logic [4:0] as_full;

  typedef struct {
    logic [3:0] acc;
    logic       carry;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_acc = 0;

  always #5 clk = ~clk;

  // behavioural add_sub: Cin=1 computes A-B as A + ~B + 1
  assign as_full = {1'b0, as_a} + {1'b0, (as_cin ? ~as_b : as_b)} + {4'b0000, as_cin};
  assign as_sum  = as_full[3:0];
  assign as_cout = as_full[4];

  addsub_acc_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .as_a(as_a), .as_b(as_b), .as_cin(as_cin), .as_sum(as_sum), .as_cout(as_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .carry(carry), .ovf(ovf), .zero(zero)
  );

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sgn4(input int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  // reference: plain integer arithmetic on the spec's rules
  function automatic exp_t model(input logic [1:0] op, input int d);
    exp_t e;
    int r, sr;
    case (op)
      2'b00: begin
        r  = m_acc + d;
        sr = sgn4(m_acc) + sgn4(d);
        e.carry = (r > 15);
      end
      2'b01: begin
        r  = m_acc - d + 16;
        sr = sgn4(m_acc) - sgn4(d);
        e.carry = (m_acc >= d);
      end
      2'b10: begin r = d; sr = 0; e.carry = 1'b0; end
      default: begin r = 0; sr = 0; e.carry = 1'b0; end
    endcase
    e.ovf = (sr > 7) || (sr < -8);
    e.acc = 4'(r % 16);
`ifdef ACC_SAT_EN
    if (e.ovf) e.acc = (sgn4(m_acc) < 0) ? 4'b1000 : 4'b0111;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_response", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_acc", int'(acc), int'(e.acc));
        chk("resp_carry", int'(carry), int'(e.carry));
        chk("resp_ovf", int'(ovf), int'(e.ovf));
        chk("resp_zero", int'(zero), int'(e.acc == 4'd0));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] data, input int hold);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", int'(in_ready), 1);
    in_valid = 1'b1; in_op = op; in_data = data;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 4'($urandom);
    e = model(op, int'(data));
    m_acc = int'(e.acc);
    q.push_back(e);
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, op[1] ? 1 : 2);
    repeat (hold) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_acc", int'(acc), m_acc);
      chk("bp_in_ready", int'(in_ready), 0);
      in_valid = 1'($urandom); in_op = 2'($urandom); in_data = 4'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = 4'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_acc", int'(acc), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_ovf", int'(ovf), 0);

    send(2'b10, 4'b1001, 0);
    send(2'b00, 4'b1110, 0);
`ifdef ACC_SAT_EN
    chk("add_ovf_acc", int'(acc), 4'b1000);
`else
    chk("add_ovf_acc", int'(acc), 4'b0111);
    chk("add_ovf_carry", int'(carry), 1);
`endif
    chk("add_ovf_flag", int'(ovf), 1);

    send(2'b10, 4'b0011, 0);
    send(2'b01, 4'b0101, 0);
    chk("sub_neg_acc", int'(acc), 4'b1110);
    chk("sub_neg_carry", int'(carry), 0);
    chk("sub_neg_ovf", int'(ovf), 0);
    chk("sub_neg_zero", int'(zero), 0);

    send(2'b10, 4'b0101, 0);
    send(2'b01, 4'b0011, 0);
    chk("sub_pos_acc", int'(acc), 4'b0010);
    chk("sub_pos_carry", int'(carry), 1);

    // backpressure with in_valid pulsing
    send(2'b00, 4'b0001, 5);

    send(2'b10, 4'b1010, 0);
    send(2'b11, 4'b0110, 0);
    chk("clear_acc", int'(acc), 0);
    chk("clear_zero", int'(zero), 1);

    // reset while in EXEC drops the command
    send(2'b10, 4'b0100, 0);
    in_valid = 1'b1; in_op = 2'b00; in_data = 4'b0011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = 0;
    chk("midrst_acc", int'(acc), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("midrst_post_acc", int'(acc), 0);
    chk("midrst_post_out_valid", int'(out_valid), 0);
    chk("midrst_post_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 300; i++)
      send(2'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
